// File: rtl/findblack_scan.sv
// ============================================================================
// findblack_scan
// ----------------------------------------------------------------------------
// Purpose:
//   Scans a rectangular window of the pixel SRAM for the first black (1)
//   pixel. The window is rows x cols words starting at base_addr, with
//   consecutive rows stride words apart. Each word holds PIX_PER_WORD 1-bit
//   pixels. The scan walks the window in row-major order (col_major=0) or
//   column-major order (col_major=1), and issues one SRAM read per cycle.
//   Read data comes back RD_LAT cycles later and is checked in arrival
//   order. The first non-zero word reported is therefore the first hit in
//   scan order. The block reports the hit word address, the pixel index
//   inside that word, and the row and column of the hit word.
//
// Parameters:
//   AW            SRAM address width
//   PIX_PER_WORD  pixels per SRAM word (power of 2, >= 2)
//   DIMW          width of the rows/cols/row/col fields
//   RD_LAT        SRAM read latency in cycles (1..3)
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   start        one-cycle scan request, honoured only while idle
//   abort        cancels a running scan with no done pulse
//   base_addr    window origin word address
//   rows, cols   window size in words
//   stride       address step between rows
//   col_major    0: columns form the inner loop, 1: rows form the inner loop
//   bit_order    0: pixel priority 0,1,2,3..  1: pair-swapped 1,0,3,2..
//   sram_rdata   SRAM read data, valid RD_LAT cycles after sram_ren
//   sram_ren     SRAM read enable
//   sram_raddr   SRAM read address
//   busy         scan in progress
//   done         one-cycle completion pulse
//   found        a black pixel was found (held until the next start)
//   hit_addr     word address of the hit
//   hit_idx      pixel index of the hit inside its word
//   hit_row      window row of the hit word
//   hit_col      window column of the hit word
//   hit_cnt      (FINDBLACK_POPCNT_EN only) number of black pixels in the
//                hit word
//
// Configuration macro:
//   FINDBLACK_POPCNT_EN  when defined, adds the hit_cnt output and the
//                        popcount logic behind it.
// ============================================================================
module findblack_scan #(
    parameter int AW           = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int DIMW         = 4,
    parameter int RD_LAT       = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [AW-1:0]                   base_addr,
    input  logic [DIMW-1:0]                 rows,
    input  logic [DIMW-1:0]                 cols,
    input  logic [AW-1:0]                   stride,
    input  logic                            col_major,
    input  logic                            bit_order,
    input  logic [PIX_PER_WORD-1:0]         sram_rdata,
    output logic                            sram_ren,
    output logic [AW-1:0]                   sram_raddr,
    output logic                            busy,
    output logic                            done,
    output logic                            found,
    output logic [AW-1:0]                   hit_addr,
    output logic [$clog2(PIX_PER_WORD)-1:0] hit_idx,
    output logic [DIMW-1:0]                 hit_row,
    output logic [DIMW-1:0]                 hit_col
`ifdef FINDBLACK_POPCNT_EN
    ,
    output logic [$clog2(PIX_PER_WORD):0]   hit_cnt
`endif
);

    localparam int IW = $clog2(PIX_PER_WORD);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    state_t state;

    // Configuration captured at start, so the inputs may change mid-scan.
    logic            cfg_col_major;
    logic            cfg_bit_order;
    logic [AW-1:0]   inner_step;
    logic [AW-1:0]   outer_step;
    logic [DIMW-1:0] inner_lim;
    logic [DIMW-1:0] outer_lim;

    // Scan position. outer_base is the address of the first word of the
    // current outer line, so each address is reached by adding a step.
    // No multiplier is needed.
    logic [DIMW-1:0] inner_cnt;
    logic [DIMW-1:0] outer_cnt;
    logic [AW-1:0]   outer_base;
    logic            ren_q;

    // Tag pipe. Stage j holds the (addr,row,col) of the read issued j cycles
    // ago. Stage RD_LAT therefore lines up with the data arriving now.
    logic            tag_v    [1:RD_LAT];
    logic [AW-1:0]   tag_addr [1:RD_LAT];
    logic [DIMW-1:0] tag_row  [1:RD_LAT];
    logic [DIMW-1:0] tag_col  [1:RD_LAT];

    logic            eval_hit;
    logic            pipe_busy;
    logic            last_word;
    logic            inner_last;
    logic [DIMW-1:0] cur_row;
    logic [DIMW-1:0] cur_col;
    logic [AW-1:0]   next_outer_base;

    // This function returns the highest-priority set pixel. The loop walks
    // priority positions from lowest to highest priority, so the last match
    // is the winner. In pair-swapped order, position p maps to pixel p^1.
    function automatic logic [IW-1:0] first_idx(input logic [PIX_PER_WORD-1:0] w,
                                                 input logic swap);
        logic [IW-1:0] idx;
        logic [IW-1:0] i;
        idx = '0;
        for (int p = PIX_PER_WORD - 1; p >= 0; p--) begin
            i = IW'(p);
            if (swap) begin
                i[0] = ~i[0];
            end
            if (w[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

`ifdef FINDBLACK_POPCNT_EN
    function automatic logic [IW:0] popcnt(input logic [PIX_PER_WORD-1:0] w);
        logic [IW:0] n;
        n = '0;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            n = n + (IW + 1)'(w[k]);
        end
        return n;
    endfunction
`endif

    // This logic decodes the scan position and the incoming data.
    // sram_ren is gated by a hit arriving this cycle. Without the gate, the
    // read that would follow a hit reaches the SRAM.
    always_comb begin
        cur_row         = cfg_col_major ? inner_cnt : outer_cnt;
        cur_col         = cfg_col_major ? outer_cnt : inner_cnt;
        inner_last      = (inner_cnt == inner_lim - DIMW'(1));
        last_word       = inner_last && (outer_cnt == outer_lim - DIMW'(1));
        next_outer_base = outer_base + outer_step;
        eval_hit        = tag_v[RD_LAT] && (|sram_rdata);
        sram_ren        = ren_q && !eval_hit;
        pipe_busy       = 1'b0;
        for (int j = 1; j <= RD_LAT; j++) begin
            pipe_busy = pipe_busy | tag_v[j];
        end
    end

    // This block holds the main FSM, the address generator, the tag pipe and
    // the result registers. An abort outside IDLE is applied last, so it
    // overrides whatever the state logic did this cycle, including a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ren_q         <= 1'b0;
            sram_raddr    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            hit_addr      <= '0;
            hit_idx       <= '0;
            hit_row       <= '0;
            hit_col       <= '0;
`ifdef FINDBLACK_POPCNT_EN
            hit_cnt       <= '0;
`endif
            cfg_col_major <= 1'b0;
            cfg_bit_order <= 1'b0;
            inner_step    <= '0;
            outer_step    <= '0;
            inner_lim     <= '0;
            outer_lim     <= '0;
            inner_cnt     <= '0;
            outer_cnt     <= '0;
            outer_base    <= '0;
            for (int j = 1; j <= RD_LAT; j++) begin
                tag_v[j]    <= 1'b0;
                tag_addr[j] <= '0;
                tag_row[j]  <= '0;
                tag_col[j]  <= '0;
            end
        end else begin
            done <= 1'b0;

            tag_v[1]    <= sram_ren;
            tag_addr[1] <= sram_raddr;
            tag_row[1]  <= cur_row;
            tag_col[1]  <= cur_col;
            for (int j = 2; j <= RD_LAT; j++) begin
                tag_v[j]    <= tag_v[j-1];
                tag_addr[j] <= tag_addr[j-1];
                tag_row[j]  <= tag_row[j-1];
                tag_col[j]  <= tag_col[j-1];
            end

            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        cfg_col_major <= col_major;
                        cfg_bit_order <= bit_order;
                        inner_step    <= col_major ? stride : AW'(1);
                        outer_step    <= col_major ? AW'(1) : stride;
                        inner_lim     <= col_major ? rows : cols;
                        outer_lim     <= col_major ? cols : rows;
                        inner_cnt     <= '0;
                        outer_cnt     <= '0;
                        outer_base    <= base_addr;
                        sram_raddr    <= base_addr;
                        found         <= 1'b0;
                        hit_addr      <= '0;
                        hit_idx       <= '0;
                        hit_row       <= '0;
                        hit_col       <= '0;
`ifdef FINDBLACK_POPCNT_EN
                        hit_cnt       <= '0;
`endif
                        if (rows == '0 || cols == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            ren_q <= 1'b1;
                            state <= ISSUE;
                        end
                    end
                end

                ISSUE, DRAIN: begin
                    if (eval_hit) begin
                        found    <= 1'b1;
                        hit_addr <= tag_addr[RD_LAT];
                        hit_idx  <= first_idx(sram_rdata, cfg_bit_order);
                        hit_row  <= tag_row[RD_LAT];
                        hit_col  <= tag_col[RD_LAT];
`ifdef FINDBLACK_POPCNT_EN
                        hit_cnt  <= popcnt(sram_rdata);
`endif
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        ren_q    <= 1'b0;
                        state    <= DONE;
                        for (int j = 1; j <= RD_LAT; j++) begin
                            tag_v[j] <= 1'b0;
                        end
                    end else if (state == ISSUE) begin
                        if (last_word) begin
                            ren_q <= 1'b0;
                            state <= DRAIN;
                        end else if (inner_last) begin
                            inner_cnt  <= '0;
                            outer_cnt  <= outer_cnt + DIMW'(1);
                            outer_base <= next_outer_base;
                            sram_raddr <= next_outer_base;
                        end else begin
                            inner_cnt  <= inner_cnt + DIMW'(1);
                            sram_raddr <= sram_raddr + inner_step;
                        end
                    end else if (!pipe_busy) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (abort && state != IDLE) begin
                state    <= IDLE;
                busy     <= 1'b0;
                done     <= 1'b0;
                ren_q    <= 1'b0;
                found    <= 1'b0;
                hit_addr <= '0;
                hit_idx  <= '0;
                hit_row  <= '0;
                hit_col  <= '0;
`ifdef FINDBLACK_POPCNT_EN
                hit_cnt  <= '0;
`endif
                for (int j = 1; j <= RD_LAT; j++) begin
                    tag_v[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_findblack_scan.sv
// ============================================================================
// tb_findblack_scan
// ----------------------------------------------------------------------------
// Testbench for findblack_scan. Two instances share one SRAM image:
//   dut_a  uses RD_LAT = 1
//   dut_b  uses RD_LAT = 3
// Each instance has its own read-latency model. Cycle numbers count from
// the edge that samples start (cycle 0).
// ============================================================================
module tb_findblack_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a;
    logic       start_b;
    logic       abort;
    logic [7:0] base_addr;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] stride;
    logic       col_major;
    logic       bit_order;

    logic [3:0] rdata_a;
    logic       ren_a;
    logic [7:0] raddr_a;
    logic       busy_a;
    logic       done_a;
    logic       found_a;
    logic [7:0] hit_addr_a;
    logic [1:0] hit_idx_a;
    logic [3:0] hit_row_a;
    logic [3:0] hit_col_a;

    logic [3:0] rdata_b;
    logic       ren_b;
    logic [7:0] raddr_b;
    logic       busy_b;
    logic       done_b;
    logic       found_b;
    logic [7:0] hit_addr_b;
    logic [1:0] hit_idx_b;
    logic [3:0] hit_row_b;
    logic [3:0] hit_col_b;

`ifdef FINDBLACK_POPCNT_EN
    logic [2:0] hit_cnt_a;
    logic [2:0] hit_cnt_b;
`endif

    logic [3:0] mem [0:255];
    logic [3:0] s1_b;
    logic [3:0] s2_b;
    logic [7:0] log_a [$];
    int         cnt_b;
    int         checks   = 0;
    int         failures = 0;
    int         dcyc;
    logic       busy1;
    logic       seen_done;

    always #5 clk = ~clk;

    findblack_scan #(.AW(8), .PIX_PER_WORD(4), .DIMW(4), .RD_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort),
        .base_addr(base_addr), .rows(rows), .cols(cols), .stride(stride),
        .col_major(col_major), .bit_order(bit_order), .sram_rdata(rdata_a),
        .sram_ren(ren_a), .sram_raddr(raddr_a), .busy(busy_a), .done(done_a),
        .found(found_a), .hit_addr(hit_addr_a), .hit_idx(hit_idx_a),
        .hit_row(hit_row_a), .hit_col(hit_col_a)
`ifdef FINDBLACK_POPCNT_EN
        , .hit_cnt(hit_cnt_a)
`endif
    );

    findblack_scan #(.AW(8), .PIX_PER_WORD(4), .DIMW(4), .RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort),
        .base_addr(base_addr), .rows(rows), .cols(cols), .stride(stride),
        .col_major(col_major), .bit_order(bit_order), .sram_rdata(rdata_b),
        .sram_ren(ren_b), .sram_raddr(raddr_b), .busy(busy_b), .done(done_b),
        .found(found_b), .hit_addr(hit_addr_b), .hit_idx(hit_idx_b),
        .hit_row(hit_row_b), .hit_col(hit_col_b)
`ifdef FINDBLACK_POPCNT_EN
        , .hit_cnt(hit_cnt_b)
`endif
    );

    // SRAM read-latency models. Cycles with no read return all-ones, so
    // data that arrives without a read tag is visibly non-zero.
    always @(posedge clk) begin
        rdata_a <= ren_a ? mem[raddr_a] : 4'hF;
        s1_b    <= ren_b ? mem[raddr_b] : 4'hF;
        s2_b    <= s1_b;
        rdata_b <= s2_b;
    end

    // Read trace: the address list for dut_a and the read count for dut_b.
    always @(posedge clk) begin
        if (ren_a === 1'b1) log_a.push_back(raddr_a);
        if (ren_b === 1'b1) cnt_b = cnt_b + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // This task starts one scan on instance `which` (0=dut_a, 1=dut_b).
    // It returns at the negedge of the done cycle, or gives -1 after a
    // bounded wait. When poke > 0, start is pulsed again in cycle poke with
    // a different base address. The running scan must ignore that pulse.
    task automatic applyStimulus(input int which, input logic [7:0] b,
                                 input logic [3:0] r, input logic [3:0] c,
                                 input logic [7:0] s, input logic cm,
                                 input logic bo, input int poke,
                                 output int done_cyc, output logic busy_c1);
        logic cur_done;
        @(negedge clk);
        base_addr = b; rows = r; cols = c; stride = s;
        col_major = cm; bit_order = bo;
        log_a.delete();
        cnt_b = 0;
        if (which == 0) start_a = 1'b1; else start_b = 1'b1;
        done_cyc = -1;
        busy_c1  = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == poke) begin
                start_a   = (which == 0);
                start_b   = (which == 1);
                base_addr = 8'h00;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (n == 1) busy_c1 = (which == 0) ? busy_a : busy_b;
            cur_done = (which == 0) ? done_a : done_b;
            if (cur_done === 1'b1) begin
                done_cyc = n;
                break;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
        base_addr = '0; rows = '0; cols = '0; stride = '0;
        col_major = 1'b0; bit_order = 1'b0; cnt_b = 0;
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        mem[8'h21] = 4'b0100;
        mem[8'h30] = 4'b0011;
        mem[8'h31] = 4'b1100;
        mem[8'h01] = 4'b1000;
        mem[8'h81] = 4'b0001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ren", ren_a, 0);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_found", found_a, 0);
        checkOutput("rst_hit_addr", hit_addr_a, 0);
        checkOutput("rst_busy_b", busy_b, 0);
        rst = 1'b0;

        // T1: row-major window; the hit is at word 4 (0x21).
        applyStimulus(0, 8'h10, 4'd2, 4'd3, 8'd16, 1'b0, 1'b0, 0, dcyc, busy1);
        checkOutput("t1_done_cyc", dcyc, 7);
        checkOutput("t1_busy_c1", busy1, 1);
        checkOutput("t1_found", found_a, 1);
        checkOutput("t1_hit_addr", hit_addr_a, 8'h21);
        checkOutput("t1_hit_idx", hit_idx_a, 2);
        checkOutput("t1_hit_row", hit_row_a, 1);
        checkOutput("t1_hit_col", hit_col_a, 1);
        checkOutput("t1_nreads", log_a.size(), 5);
        if (log_a.size() == 5) begin
            checkOutput("t1_rd2", log_a[2], 8'h12);
            checkOutput("t1_rd3", log_a[3], 8'h20);
            checkOutput("t1_rd4", log_a[4], 8'h21);
        end

        // T2: the same window in column-major order.
        applyStimulus(0, 8'h10, 4'd2, 4'd3, 8'd16, 1'b1, 1'b0, 0, dcyc, busy1);
        checkOutput("t2_done_cyc", dcyc, 6);
        checkOutput("t2_hit_addr", hit_addr_a, 8'h21);
        checkOutput("t2_hit_row", hit_row_a, 1);
        checkOutput("t2_hit_col", hit_col_a, 1);
        checkOutput("t2_nreads", log_a.size(), 4);
        if (log_a.size() == 4) checkOutput("t2_rd1", log_a[1], 8'h20);

        // T3: pixel priority order, using 1x1 windows.
        applyStimulus(0, 8'h30, 4'd1, 4'd1, 8'd16, 1'b0, 1'b0, 0, dcyc, busy1);
        checkOutput("t3_done_cyc", dcyc, 3);
        checkOutput("t3_idx_bo0", hit_idx_a, 0);
        checkOutput("t3_row0", hit_row_a, 0);
`ifdef FINDBLACK_POPCNT_EN
        checkOutput("t3_cnt", hit_cnt_a, 2);
`endif
        applyStimulus(0, 8'h30, 4'd1, 4'd1, 8'd16, 1'b0, 1'b1, 0, dcyc, busy1);
        checkOutput("t3_idx_bo1", hit_idx_a, 1);
        applyStimulus(0, 8'h31, 4'd1, 4'd1, 8'd16, 1'b0, 1'b1, 0, dcyc, busy1);
        checkOutput("t3_idx_1100_bo1", hit_idx_a, 3);

        // T4: an all-zero 3x3 window with RD_LAT=3, then a hit with RD_LAT=3.
        applyStimulus(1, 8'h40, 4'd3, 4'd3, 8'd16, 1'b0, 1'b0, 0, dcyc, busy1);
        checkOutput("t4_done_cyc", dcyc, 14);
        checkOutput("t4_nreads", cnt_b, 9);
        checkOutput("t4_found", found_b, 0);
        checkOutput("t4_hit_addr", hit_addr_b, 0);
        applyStimulus(1, 8'h10, 4'd2, 4'd3, 8'd16, 1'b0, 1'b0, 0, dcyc, busy1);
        checkOutput("t4_lat3_done_cyc", dcyc, 9);
        checkOutput("t4_lat3_hit_addr", hit_addr_b, 8'h21);
        checkOutput("t4_lat3_nreads", cnt_b, 6);

        // Zero-size window: found must be cleared from the previous hit.
        applyStimulus(0, 8'h10, 4'd0, 4'd3, 8'd16, 1'b0, 1'b0, 0, dcyc, busy1);
        checkOutput("t4_zero_done_cyc", dcyc, 1);
        checkOutput("t4_zero_found", found_a, 0);
        repeat (3) @(negedge clk);
        checkOutput("t4_zero_nreads", log_a.size(), 0);

        // T5: address wrap, with a start pulse while busy.
        applyStimulus(0, 8'hF0, 4'd2, 4'd2, 8'h10, 1'b0, 1'b0, 2, dcyc, busy1);
        checkOutput("t5_done_cyc", dcyc, 6);
        checkOutput("t5_hit_addr", hit_addr_a, 8'h01);
        checkOutput("t5_hit_idx", hit_idx_a, 3);
        checkOutput("t5_hit_row", hit_row_a, 1);
        if (log_a.size() >= 3) checkOutput("t5_rd_wrap", log_a[2], 8'h00);
        else checkOutput("t5_nreads", log_a.size(), 4);

        // T6: abort in cycle 3 of a 4x4 scan, in the same cycle as a hit.
        @(negedge clk);
        base_addr = 8'h80; rows = 4'd4; cols = 4'd4; stride = 8'd16;
        col_major = 1'b0; bit_order = 1'b0;
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("t6_busy", busy_a, 0);
        checkOutput("t6_ren", ren_a, 0);
        checkOutput("t6_found", found_a, 0);
        seen_done = done_a;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done_a === 1'b1) seen_done = 1'b1;
        end
        checkOutput("t6_no_done", seen_done, 0);
        checkOutput("t6_found_late", found_a, 0);

        // Reset mid-scan, followed by a new scan.
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checkOutput("t6_rst_busy", busy_a, 0);
        checkOutput("t6_rst_ren", ren_a, 0);
        checkOutput("t6_rst_hit_addr", hit_addr_a, 0);
        checkOutput("t6_rst_found", found_a, 0);
        applyStimulus(0, 8'h10, 4'd2, 4'd3, 8'd16, 1'b0, 1'b0, 0, dcyc, busy1);
        checkOutput("t6_rerun_done_cyc", dcyc, 7);
        checkOutput("t6_rerun_hit_addr", hit_addr_a, 8'h21);
        checkOutput("t6_rerun_found", found_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
